// File: rtl/cpu_pkg.sv
// Shared opcodes, ALU codes, FSM states and control bundle for the
// control unit slice (see control_unit.sv for the port list).
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'h00;
  localparam logic [4:0] OP_LDI  = 5'h01;
  localparam logic [4:0] OP_ST   = 5'h02;
  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_OR   = 5'h06;
  localparam logic [4:0] OP_SHR  = 5'h07;
  localparam logic [4:0] OP_SHL  = 5'h08;
  localparam logic [4:0] OP_ROR  = 5'h09;
  localparam logic [4:0] OP_ROL  = 5'h0A;
  localparam logic [4:0] OP_ADDI = 5'h0B;
  localparam logic [4:0] OP_ANDI = 5'h0C;
  localparam logic [4:0] OP_ORI  = 5'h0D;
  localparam logic [4:0] OP_MUL  = 5'h0E;
  localparam logic [4:0] OP_DIV  = 5'h0F;
  localparam logic [4:0] OP_BRZR = 5'h12;
  localparam logic [4:0] OP_JR   = 5'h13;
  localparam logic [4:0] OP_IN   = 5'h15;
  localparam logic [4:0] OP_OUT  = 5'h16;
  localparam logic [4:0] OP_MFHI = 5'h17;
  localparam logic [4:0] OP_MFLO = 5'h18;
  localparam logic [4:0] OP_NOP  = 5'h19;
  localparam logic [4:0] OP_HALT = 5'h1A;

  localparam logic [4:0] ALU_ADD = 5'h03;
  localparam logic [4:0] ALU_AND = 5'h05;
  localparam logic [4:0] ALU_OR  = 5'h06;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LD, C_LDI, C_ST,
    C_BR, C_ONE_STEP, C_MULDIV, C_ILLEGAL
  } iclass_t;

  typedef struct packed {
    logic       hi_in;
    logic       lo_in;
    logic       z_in;
    logic       pc_in;
    logic       mdr_in;
    logic       mar_in;
    logic       y_in;
    logic       oport_in;
    logic       ir_in;
    logic       hi_out;
    logic       lo_out;
    logic       zhi_out;
    logic       zlo_out;
    logic       pc_out;
    logic       mdr_out;
    logic       iport_out;
    logic       c_out;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       ba_out;
    logic       con_in;
    logic       mem_read;
    logic       mem_write;
    logic       run;
    logic [4:0] alu;
  } ctrl_t;

  function automatic logic [4:0] imm_alu(input logic [4:0] op);
    logic [4:0] r;
    r = ALU_ADD;
    if (op == OP_ANDI) r = ALU_AND;
    if (op == OP_ORI)  r = ALU_OR;
    return r;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Opcode -> instruction class, purely combinational.
// Ports: opcode (IR[31:27]) in, iclass out. Macro: CONTROL_UNIT_MUL_DIV_EN.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    iclass
);

  always_comb begin
    iclass = C_ILLEGAL;
    unique case (1'b1)
      (opcode >= OP_ADD && opcode <= OP_ROL):
        iclass = C_ALU_R;
      (opcode >= OP_ADDI && opcode <= OP_ORI):
        iclass = C_ALU_I;
      (opcode == OP_LD):   iclass = C_LD;
      (opcode == OP_LDI):  iclass = C_LDI;
      (opcode == OP_ST):   iclass = C_ST;
      (opcode == OP_BRZR): iclass = C_BR;
      (opcode == OP_JR),
      (opcode >= OP_IN && opcode <= OP_NOP):
        iclass = C_ONE_STEP;
`ifdef CONTROL_UNIT_MUL_DIV_EN
      (opcode == OP_MUL || opcode == OP_DIV):
        iclass = C_MULDIV;
`endif
      default: iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore control unit: fetch T0-T2, execute T3-T7, HALT until clear.
// Ports: clock, clear (async low), opcode, ConOut, stop in; DataPath
// strobes, ALUCode, run out. Macro CONTROL_UNIT_MUL_DIV_EN adds mul/div.
module control_unit
  import cpu_pkg::*;
#(
  parameter logic [4:0] INC_CODE = 5'b11111
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [4:0] opcode,
  input  logic       ConOut,
  input  logic       stop,
  output logic       HiIn,
  output logic       LoIn,
  output logic       ZIn,
  output logic       PCIn,
  output logic       MDRIn,
  output logic       MARIn,
  output logic       YIn,
  output logic       OPortIn,
  output logic       IRIn,
  output logic       HiOut,
  output logic       LoOut,
  output logic       ZHiOut,
  output logic       ZLoOut,
  output logic       PCOut,
  output logic       MDROut,
  output logic       IPortOut,
  output logic       COut,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       RIn,
  output logic       ROut,
  output logic       BAOut,
  output logic       Conin,
  output logic       memread,
  output logic       memwrite,
  output logic [4:0] ALUCode,
  output logic       run
);

  state_t  state;
  iclass_t iclass;
  ctrl_t   c;

  cu_decode u_decode (
    .opcode (opcode),
    .iclass (iclass)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_RESET;
    end else begin
      unique case (state)
        S_RESET: state <= S_T0;
        S_T0:    state <= stop ? S_HALT : S_T1;
        S_T1:    state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3: begin
          if (iclass == C_ILLEGAL)
            state <= S_HALT;
          else if (iclass == C_ONE_STEP)
            state <= S_T0;
          else
            state <= S_T4;
        end
        S_T4:    state <= S_T5;
        S_T5: begin
          if (iclass == C_ALU_R || iclass == C_ALU_I ||
              iclass == C_LDI)
            state <= S_T0;
          else
            state <= S_T6;
        end
        S_T6: begin
          if (iclass == C_LD || iclass == C_ST)
            state <= S_T7;
          else
            state <= S_T0;
        end
        S_T7:    state <= S_T0;
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

  always_comb begin
    c = '0;
    c.run = (state != S_RESET) && (state != S_HALT);
    case (state)
      S_T0: begin
        c.pc_out = 1'b1;
        c.mar_in = 1'b1;
        c.z_in   = 1'b1;
        c.alu    = INC_CODE;
      end
      S_T1: begin
        c.zlo_out  = 1'b1;
        c.pc_in    = 1'b1;
        c.mem_read = 1'b1;
        c.mdr_in   = 1'b1;
      end
      S_T2: begin
        c.mdr_out = 1'b1;
        c.ir_in   = 1'b1;
      end
      S_T3: begin
        case (iclass)
          C_ALU_R, C_ALU_I: begin
            c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
          end
          C_LD, C_LDI, C_ST: begin
            c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
          end
          C_BR: begin
            c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1;
          end
          C_ONE_STEP: begin
            case (opcode)
              OP_JR: begin
                c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1;
              end
              OP_IN: begin
                c.iport_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
              end
              OP_OUT: begin
                c.gra = 1'b1; c.r_out = 1'b1; c.oport_in = 1'b1;
              end
              OP_MFHI: begin
                c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
              end
              OP_MFLO: begin
                c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
              end
              default: ;
            endcase
          end
`ifdef CONTROL_UNIT_MUL_DIV_EN
          C_MULDIV: begin
            c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T4: begin
        case (iclass)
          C_ALU_R: begin
            c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1;
            c.alu = opcode;
          end
          C_ALU_I: begin
            c.c_out = 1'b1; c.z_in = 1'b1;
            c.alu = imm_alu(opcode);
          end
          C_LD, C_LDI, C_ST: begin
            c.c_out = 1'b1; c.z_in = 1'b1; c.alu = ALU_ADD;
          end
          C_BR: begin
            c.pc_out = 1'b1; c.y_in = 1'b1;
          end
`ifdef CONTROL_UNIT_MUL_DIV_EN
          C_MULDIV: begin
            c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1;
            c.alu = opcode;
          end
`endif
          default: ;
        endcase
      end
      S_T5: begin
        case (iclass)
          C_ALU_R, C_ALU_I, C_LDI: begin
            c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end
          C_LD, C_ST: begin
            c.zlo_out = 1'b1; c.mar_in = 1'b1;
          end
          C_BR: begin
            c.c_out = 1'b1; c.z_in = 1'b1; c.alu = ALU_ADD;
          end
`ifdef CONTROL_UNIT_MUL_DIV_EN
          C_MULDIV: begin
            c.zlo_out = 1'b1; c.lo_in = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T6: begin
        case (iclass)
          C_LD: begin
            c.mem_read = 1'b1; c.mdr_in = 1'b1;
          end
          C_ST: begin
            c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1;
          end
          C_BR: begin
            // PC only reloads when the branch condition holds.
            c.zlo_out = 1'b1; c.pc_in = ConOut;
          end
`ifdef CONTROL_UNIT_MUL_DIV_EN
          C_MULDIV: begin
            c.zhi_out = 1'b1; c.hi_in = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T7: begin
        case (iclass)
          C_LD: begin
            c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end
          C_ST: c.mem_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign HiIn     = c.hi_in;
  assign LoIn     = c.lo_in;
  assign ZIn      = c.z_in;
  assign PCIn     = c.pc_in;
  assign MDRIn    = c.mdr_in;
  assign MARIn    = c.mar_in;
  assign YIn      = c.y_in;
  assign OPortIn  = c.oport_in;
  assign IRIn     = c.ir_in;
  assign HiOut    = c.hi_out;
  assign LoOut    = c.lo_out;
  assign ZHiOut   = c.zhi_out;
  assign ZLoOut   = c.zlo_out;
  assign PCOut    = c.pc_out;
  assign MDROut   = c.mdr_out;
  assign IPortOut = c.iport_out;
  assign COut     = c.c_out;
  assign Gra      = c.gra;
  assign Grb      = c.grb;
  assign Grc      = c.grc;
  assign RIn      = c.r_in;
  assign ROut     = c.r_out;
  assign BAOut    = c.ba_out;
  assign Conin    = c.con_in;
  assign memread  = c.mem_read;
  assign memwrite = c.mem_write;
  assign ALUCode  = c.alu;
  assign run      = c.run;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected control vectors
// come from a micro-program table model; a negedge monitor compares.
module tb_control_unit;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic       ConOut = 1'b0;
  logic       stop = 1'b0;
  logic HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
  logic HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut;
  logic Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite;
  logic [4:0] ALUCode;
  logic run;

  control_unit dut (
    .clock(clock), .clear(clear), .opcode(opcode),
    .ConOut(ConOut), .stop(stop),
    .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn),
    .MDRIn(MDRIn), .MARIn(MARIn), .YIn(YIn),
    .OPortIn(OPortIn), .IRIn(IRIn),
    .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut),
    .ZLoOut(ZLoOut), .PCOut(PCOut), .MDROut(MDROut),
    .IPortOut(IPortOut), .COut(COut),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .RIn(RIn), .ROut(ROut),
    .BAOut(BAOut), .Conin(Conin),
    .memread(memread), .memwrite(memwrite),
    .ALUCode(ALUCode), .run(run)
  );

  always #5 clock = ~clock;

  localparam logic [31:0] M_HIIN  = 32'd1 << 31;
  localparam logic [31:0] M_LOIN  = 32'd1 << 30;
  localparam logic [31:0] M_ZIN   = 32'd1 << 29;
  localparam logic [31:0] M_PCIN  = 32'd1 << 28;
  localparam logic [31:0] M_MDRIN = 32'd1 << 27;
  localparam logic [31:0] M_MARIN = 32'd1 << 26;
  localparam logic [31:0] M_YIN   = 32'd1 << 25;
  localparam logic [31:0] M_OPIN  = 32'd1 << 24;
  localparam logic [31:0] M_IRIN  = 32'd1 << 23;
  localparam logic [31:0] M_HIOUT = 32'd1 << 22;
  localparam logic [31:0] M_LOOUT = 32'd1 << 21;
  localparam logic [31:0] M_ZHI   = 32'd1 << 20;
  localparam logic [31:0] M_ZLO   = 32'd1 << 19;
  localparam logic [31:0] M_PCOUT = 32'd1 << 18;
  localparam logic [31:0] M_MDROUT= 32'd1 << 17;
  localparam logic [31:0] M_IPOUT = 32'd1 << 16;
  localparam logic [31:0] M_COUT  = 32'd1 << 15;
  localparam logic [31:0] M_GRA   = 32'd1 << 14;
  localparam logic [31:0] M_GRB   = 32'd1 << 13;
  localparam logic [31:0] M_GRC   = 32'd1 << 12;
  localparam logic [31:0] M_RIN   = 32'd1 << 11;
  localparam logic [31:0] M_ROUT  = 32'd1 << 10;
  localparam logic [31:0] M_BAOUT = 32'd1 << 9;
  localparam logic [31:0] M_CONIN = 32'd1 << 8;
  localparam logic [31:0] M_MRD   = 32'd1 << 7;
  localparam logic [31:0] M_MWR   = 32'd1 << 6;
  localparam logic [31:0] M_RUN   = 32'd1 << 5;

  logic [31:0] dut_vec;
  assign dut_vec = {HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn,
                    OPortIn, IRIn, HiOut, LoOut, ZHiOut, ZLoOut,
                    PCOut, MDROut, IPortOut, COut, Gra, Grb, Grc,
                    RIn, ROut, BAOut, Conin, memread, memwrite,
                    run, ALUCode};

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] prog[$];
  bit halts;
  string tag = "reset";

  function automatic logic [31:0] alu(input logic [4:0] a);
    return {27'd0, a};
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) cmp(tag, dut_vec, sb.pop_front());
  end

  // Micro-program table: one entry per clock the DUT spends running.
  task automatic build(input logic [4:0] op, input logic con);
    int o;
    o = int'(op);
    prog = {};
    halts = 0;
    prog.push_back(M_PCOUT | M_MARIN | M_ZIN | alu(5'h1F));
    prog.push_back(M_ZLO | M_PCIN | M_MRD | M_MDRIN);
    prog.push_back(M_MDROUT | M_IRIN);
    if (o >= 3 && o <= 10) begin
      prog.push_back(M_GRB | M_ROUT | M_YIN);
      prog.push_back(M_GRC | M_ROUT | M_ZIN | alu(op));
      prog.push_back(M_ZLO | M_GRA | M_RIN);
    end else if (o >= 11 && o <= 13) begin
      prog.push_back(M_GRB | M_ROUT | M_YIN);
      prog.push_back(M_COUT | M_ZIN |
                     alu(o == 11 ? 5'h03 : o == 12 ? 5'h05 : 5'h06));
      prog.push_back(M_ZLO | M_GRA | M_RIN);
    end else if (o <= 2) begin
      prog.push_back(M_GRB | M_BAOUT | M_YIN);
      prog.push_back(M_COUT | M_ZIN | alu(5'h03));
      if (o == 1) prog.push_back(M_ZLO | M_GRA | M_RIN);
      else prog.push_back(M_ZLO | M_MARIN);
      if (o == 0) begin
        prog.push_back(M_MRD | M_MDRIN);
        prog.push_back(M_MDROUT | M_GRA | M_RIN);
      end
      if (o == 2) begin
        prog.push_back(M_GRA | M_ROUT | M_MDRIN);
        prog.push_back(M_MWR);
      end
    end else if (o == 18) begin
      prog.push_back(M_GRA | M_ROUT | M_CONIN);
      prog.push_back(M_PCOUT | M_YIN);
      prog.push_back(M_COUT | M_ZIN | alu(5'h03));
      prog.push_back(M_ZLO | (con ? M_PCIN : 32'd0));
    end else if (o == 19) prog.push_back(M_GRA | M_ROUT | M_PCIN);
    else if (o == 21) prog.push_back(M_IPOUT | M_GRA | M_RIN);
    else if (o == 22) prog.push_back(M_GRA | M_ROUT | M_OPIN);
    else if (o == 23) prog.push_back(M_HIOUT | M_GRA | M_RIN);
    else if (o == 24) prog.push_back(M_LOOUT | M_GRA | M_RIN);
    else if (o == 25) prog.push_back(32'd0);
`ifdef CONTROL_UNIT_MUL_DIV_EN
    else if (o == 14 || o == 15) begin
      prog.push_back(M_GRA | M_ROUT | M_YIN);
      prog.push_back(M_GRB | M_ROUT | M_ZIN | alu(op));
      prog.push_back(M_ZLO | M_LOIN);
      prog.push_back(M_ZHI | M_HIIN);
    end
`endif
    else begin
      prog.push_back(32'd0);
      halts = 1;
    end
    foreach (prog[i]) prog[i] = prog[i] | M_RUN;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_cycle(input logic [31:0] v);
    sb.push_back(v);
    step();
  endtask

  task automatic do_reset();
    clear = 1'b0;
    expect_cycle(32'd0);
    expect_cycle(32'd0);
    clear = 1'b1;
    expect_cycle(32'd0);
  endtask

  task automatic halt_tail();
    repeat (3) expect_cycle(32'd0);
    do_reset();
  endtask

  task automatic run_instr(input logic [4:0] op, input logic con,
                           input bit stop0);
    build(op, con);
    $sformat(tag, "op%02h", op);
    opcode = op;
    ConOut = con;
    if (stop0) begin
      tag = "stop";
      stop = 1'b1;
      expect_cycle(prog[0]);
      stop = 1'b0;
      halt_tail();
      return;
    end
    foreach (prog[i]) begin
      stop = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      expect_cycle(prog[i]);
    end
    stop = 1'b0;
    if (halts) halt_tail();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    step();
    do_reset();
    run_instr(5'h03, 1'b0, 0);
    run_instr(5'h02, 1'b0, 0);
    run_instr(5'h12, 1'b0, 0);
    run_instr(5'h12, 1'b1, 0);
    run_instr(5'h0E, 1'b0, 0);
    run_instr(5'h00, 1'b0, 0);
    run_instr(5'h03, 1'b0, 1);
    // async clear in the middle of ld (T5)
    build(5'h00, 1'b0);
    tag = "ld_clr";
    opcode = 5'h00;
    for (int i = 0; i < 6; i++) begin
      sb.push_back(prog[i]);
      if (i < 5) step();
    end
    @(negedge clock);
    #1 clear = 1'b0;
    #1 cmp("async_clear", dut_vec, 32'd0);
    step();
    clear = 1'b1;
    expect_cycle(32'd0);
    run_instr(5'h01, 1'b1, 0);
    for (int n = 0; n < 250; n++) begin
      run_instr(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 15) == 0);
    end
    @(negedge clock);
    #1 cmp("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter INC_CODE, default 5'b11111, ALUCode value selecting PC increment during fetch.
REQ-002 SHALL have port clock, input, 1, single system clock; all state changes on rising edge.
REQ-003 SHALL have port clear, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port opcode, input, 5, IR[31:27] from DataPath, valid from T3 onward.
REQ-005 SHALL have port ConOut, input, 1, branch condition flip-flop from DataPath.
REQ-006 SHALL have port stop, input, 1, halt request, sampled only in T0.
REQ-007 SHALL have ports HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn, output, 1 each, DataPath register load strobes.
REQ-008 SHALL have ports HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut, output, 1 each, bus drive strobes.
REQ-009 SHALL have ports Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite, output, 1 each, register-file, branch and memory controls.
REQ-010 SHALL have port ALUCode, output, 5, ALU operation select.
REQ-011 SHALL have port run, output, 1, high while executing, low in reset and HALT.

Function
REQ-012 SHALL be a Moore FSM: controls decode from present state (plus opcode/ConOut where stated); unlisted controls 0 in every state.
REQ-013 SHALL use fetch states T0: PCOut MARIn ZIn ALUCode=INC_CODE; T1: ZLoOut PCIn memread MDRIn; T2: MDROut IRIn.
REQ-014 SHALL decode opcode in T3; every instruction returns to T0 after its last state.
REQ-015 R-type ALU (add 03, sub 04, and 05, or 06, shr 07, shl 08, ror 09, rol 0A) SHALL run T3 Grb ROut YIn; T4 Grc ROut ZIn ALUCode=opcode; T5 ZLoOut Gra RIn.
REQ-016 Immediate (addi 0B, andi 0C, ori 0D) SHALL match REQ-015 with T4 COut replacing Grc ROut and ALUCode 03/05/06 respectively.
REQ-017 ld 00 SHALL run T3 Grb BAOut YIn; T4 COut ZIn ALUCode=03; T5 ZLoOut MARIn; T6 memread MDRIn; T7 MDROut Gra RIn.
REQ-018 ldi 01 SHALL run T3-T4 as ld; T5 ZLoOut Gra RIn.
REQ-019 st 02 SHALL run T3-T5 as ld; T6 Gra ROut MDRIn; T7 memwrite.
REQ-020 brzr 12 SHALL run T3 Gra ROut Conin; T4 PCOut YIn; T5 COut ZIn ALUCode=03; T6 ZLoOut and PCIn=ConOut.
REQ-021 jr 13: T3 Gra ROut PCIn. in 15: T3 IPortOut Gra RIn. out 16: T3 Gra ROut OPortIn. mfhi 17: T3 HiOut Gra RIn. mflo 18: T3 LoOut Gra RIn. nop 19: T3 only, no controls.
REQ-022 halt 1A and any unlisted opcode SHALL enter HALT from T3; HALT holds all controls 0, run=0, until clear.
REQ-023 stop high in T0 SHALL enter HALT next edge instead of T1; stop elsewhere ignored; in-flight instruction always completes.

Reset
REQ-024 clear low SHALL immediately force state RESET, all outputs 0, run=0, regardless of state.
REQ-025 First rising edge after clear high SHALL enter T0 with run=1.

Configuration
REQ-026 Macro CONTROL_UNIT_MUL_DIV_EN defined: mul 0E / div 0F SHALL run T3 Gra ROut YIn; T4 Grb ROut ZIn ALUCode=opcode; T5 ZLoOut LoIn; T6 ZHiOut HiIn.
REQ-027 Macro undefined: 0E/0F SHALL be illegal per REQ-022; no extra states synthesized.

Structure
REQ-028 Package cpu_pkg SHALL hold opcode constants, ALU code constants, and state enum (RESET, T0-T7, HALT).
REQ-029 Sub-module cu_decode SHALL map opcode to instruction class (ALU_R, ALU_I, LD, LDI, ST, BR, ONE_STEP, MULDIV, ILLEGAL), purely combinational.

Verification
REQ-030 clear low 2 cycles then high -> all outputs 0 during reset; T0 next edge with PCOut=MARIn=ZIn=1, ALUCode=11111, run=1.
REQ-031 opcode 03 -> T3 Grb/ROut/YIn, T4 Grc/ROut/ZIn ALUCode=00011, T5 ZLoOut/Gra/RIn, T0 on sixth cycle after T0.
REQ-032 opcode 02 -> T6 Gra/ROut/MDRIn, T7 memwrite=1 exactly one cycle, memread never asserted after T1.
REQ-033 opcode 12 twice, ConOut=0 then 1 -> PCIn low then high in T6; identical for all other outputs.
REQ-034 opcode 0E -> with macro: LoIn in T5, HiIn in T6; without: HALT after T3, run=0.
REQ-035 stop=1 in T0 -> HALT next edge; clear pulse low in T5 of ld -> outputs 0 asynchronously, restart at T0.
